// File: rtl/ahb_pkg.sv
// Shared AHB definitions: bus encodings plus the SRAM slave's state type and
// byte-lane helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_e;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_RD_DATA,
    S_RD_STALL,
    S_ERR1,
    S_ERR2
  } ahb_sram_state_e;

  // Lanes covered by a 2^size byte transfer starting at byte offset within the beat.
  function automatic logic [7:0] byte_enable(input logic [2:0] size, input logic [2:0] offset);
    return 8'(((16'd1 << (8'd1 << size)) - 16'd1) << offset);
  endfunction

endpackage

// File: rtl/ahb_sram_addr_dec.sv
// Address-phase decode for the SRAM slave: legality, byte lanes and word
// address, all combinational from the live haddr/hsize.
module ahb_sram_addr_dec
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic [ADDR_WIDTH-1:0]        haddr,
  input  logic [2:0]                   hsize,
  output logic                         legal,
  output logic [DATA_WIDTH/8-1:0]      be,
  output logic [$clog2(MEM_DEPTH)-1:0] word_addr
);

  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int AW         = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(MEM_DEPTH * (DATA_WIDTH / 8));

  logic       size_ok;
  logic       aligned;
  logic       in_range;
  logic [2:0] offset;
  logic [7:0] mask;
  logic       unused_mask;

  always_comb begin
    offset = '0;
    offset[BYTE_SHIFT-1:0] = haddr[BYTE_SHIFT-1:0];
    size_ok = (hsize <= 3'(BYTE_SHIFT));
    aligned = 1'b1;
    for (int i = 0; i < BYTE_SHIFT; i++) begin
      if (haddr[i] && (i < int'(hsize))) aligned = 1'b0;
    end
    in_range  = ({1'b0, haddr} < SPAN);
    legal     = size_ok & aligned & in_range;
    mask      = byte_enable(hsize, offset);
    be        = mask[DATA_WIDTH/8-1:0];
    word_addr = haddr[BYTE_SHIFT +: AW];
  end

  // Upper lanes of the helper mask only matter for 64-bit builds.
  assign unused_mask = ^mask;

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave fronting a single-port synchronous SRAM; reads issue in the address
// phase, writes in the data phase, with one stall when both collide.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic                         hsel,
  input  logic [ADDR_WIDTH-1:0]        haddr,
  input  logic [1:0]                   htrans,
  input  logic                         hwrite,
  input  logic [2:0]                   hsize,
  input  logic [2:0]                   hburst,
  input  logic [3:0]                   hprot,
  input  logic [DATA_WIDTH-1:0]        hwdata,
  input  logic                         hready,
  output logic                         hreadyout,
  output logic [1:0]                   hresp,
  output logic [DATA_WIDTH-1:0]        hrdata,
  output logic                         sram_cs,
  output logic                         sram_we,
  output logic [DATA_WIDTH/8-1:0]      sram_be,
  output logic [$clog2(MEM_DEPTH)-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]        sram_wdata,
  input  logic [DATA_WIDTH-1:0]        sram_rdata
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int NB = DATA_WIDTH / 8;

  ahb_sram_state_e state;
  logic [AW-1:0]   wr_addr;
  logic [NB-1:0]   wr_be;
  logic            legal;
  logic [NB-1:0]   dec_be;
  logic [AW-1:0]   dec_addr;
  logic            accept;
  logic            rd_conflict;
  logic            unused_inputs;

  ahb_sram_addr_dec #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_addr_dec (
    .haddr    (haddr),
    .hsize    (hsize),
    .legal    (legal),
    .be       (dec_be),
    .word_addr(dec_addr)
  );

  assign accept = hsel & hready & htrans[1];

  // Conflict is judged without hready: hready is our own hreadyout during a
  // write data phase, so using it here would close a combinational loop.
  assign rd_conflict = (state == S_WR_DATA) & hsel & htrans[1] & ~hwrite & legal;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= S_IDLE;
      wr_addr <= '0;
      wr_be   <= '0;
    end else if (rd_conflict) begin
      state <= S_RD_STALL;
    end else if (state == S_ERR1) begin
      state <= S_ERR2;
    end else if (accept && !legal) begin
      state <= S_ERR1;
    end else if (accept && hwrite) begin
      state   <= S_WR_DATA;
      wr_addr <= dec_addr;
      wr_be   <= dec_be;
    end else if (accept) begin
      state <= S_RD_DATA;
    end else begin
      state <= S_IDLE;
    end
  end

  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = '0;
    sram_addr  = dec_addr;
    sram_wdata = hwdata;
    if (state == S_WR_DATA) begin
      sram_cs   = 1'b1;
      sram_we   = 1'b1;
      sram_be   = wr_be;
      sram_addr = wr_addr;
    end else if (accept && legal && !hwrite) begin
      sram_cs = 1'b1;
    end
  end

  assign hreadyout = (state != S_ERR1) && !rd_conflict;
  assign hresp     = ((state == S_ERR1) || (state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata    = (state == S_RD_DATA) ? sram_rdata : '0;

  // Burst type, protection and the BUSY/SEQ distinction do not affect a flat SRAM.
  assign unused_inputs = ^{hburst, hprot, htrans[0]};

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB slave that consumes transfers driven on the team's AHB interface and maps them onto a single-port synchronous SRAM macro. It is the memory endpoint of the AHB-RAM subsystem. The block:
- pipelines address and data phases;
- generates byte enables from hsize;
- inserts one wait state on write-to-read port conflicts;
- returns the two-cycle ERROR response for illegal transfers.

Parameters:
ADDR_WIDTH, 32, width of haddr.
DATA_WIDTH, 32, width of hwdata/hrdata/sram data; legal values 32 or 64.
MEM_DEPTH, 4096, SRAM depth in DATA_WIDTH words; byte span = MEM_DEPTH*DATA_WIDTH/8.

Ports:
hclk  in  1  bus clock
hresetn  in  1  asynchronous active-low reset
hsel  in  1  slave select
haddr  in  ADDR_WIDTH  byte address (address phase)
htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hwrite  in  1  1=write
hsize  in  3  log2 of transfer bytes
hburst  in  3  accepted, not used for addressing
hprot  in  4  ignored
hwdata  in  DATA_WIDTH  write data (data phase)
hready  in  1  bus-level ready (previous transfer complete)
hreadyout  out  1  this slave's ready
hresp  out  2  OKAY=0, ERROR=1 (RETRY/SPLIT never driven)
hrdata  out  DATA_WIDTH  read data
sram_cs  out  1  SRAM access strobe
sram_we  out  1  1=write
sram_be  out  DATA_WIDTH/8  byte write enables
sram_addr  out  clog2(MEM_DEPTH)  word address
sram_wdata  out  DATA_WIDTH  write data
sram_rdata  in  DATA_WIDTH  read data, valid the cycle after a read strobe

Behaviour:
- Reset values: hreadyout=1, hresp=0, hrdata=0, sram_cs=0, sram_we=0, sram_be=0. Reset is asynchronous; asserting it mid-transfer drops any pending write and returns the FSM to IDLE.
- Transfer accepted when hsel & hready & htrans[1]. IDLE/BUSY or hsel=0 get a zero-wait OKAY with no SRAM access.
- Legality check on accept:
  - hsize <= log2(DATA_WIDTH/8);
  - haddr aligned to 2^hsize;
  - haddr < byte span.
  - Any failure: transfer is illegal and performs no SRAM access.
- Byte enable: be = ((1<<(1<<hsize))-1) << haddr[log2(DATA_WIDTH/8)-1:0]. Word address = haddr >> log2(DATA_WIDTH/8).
- FSM states: IDLE, WR_DATA, RD_DATA, RD_STALL, ERR1, ERR2.
  - Read accepted (from IDLE/RD_DATA): sram_cs=1, we=0, addr from live haddr in the same cycle. Next state RD_DATA, where hrdata=sram_rdata and hreadyout=1. Latency: zero wait states.
  - Write accepted: address/be/size registered; next state WR_DATA. In WR_DATA: sram_cs=1, we=1, be/addr from registers, sram_wdata=hwdata.
  - Read accepted while in WR_DATA (port conflict): the write uses the port that cycle, hreadyout=0, next state RD_STALL.
  - RD_STALL: read issued from the held haddr, hreadyout=1, next state RD_DATA. This gives exactly one wait state.
  - Write accepted in WR_DATA: back-to-back writes, zero wait.
  - Illegal transfer accepted: next state ERR1 (hreadyout=0, hresp=ERROR), then ERR2 (hreadyout=1, hresp=ERROR). A new transfer accepted in ERR2 is handled normally.
  - Data-phase states with no new accept return to IDLE.
- hrdata=0 outside RD_DATA.
- hresp=OKAY in all non-ERR states.
- Write data outside the enabled byte lanes is ignored by the SRAM via sram_be.

Decomposition:
- Shared package ahb_pkg: existing enums for response, trans type, size and burst. Add the state enum ahb_sram_state_e and a function computing the byte-enable mask.
- One sub-module, ahb_sram_addr_dec: combinational legality check, byte-enable and word-address generation.

Test Plan:
- Word write 0xDEADBEEF @0x10, then read @0x10 -> write completes zero-wait; hrdata=0xDEADBEEF in the read data phase.
- Byte writes 0x11,0x22,0x33,0x44 @0x20..0x23 (hsize=0), then word read @0x20 -> sram_be 0x1,0x2,0x4,0x8 in turn; hrdata=0x44332211.
- Write @0x30 immediately followed by read @0x30 -> one cycle with hreadyout=0 during the write data phase; read returns the just-written data.
- Read @byte span (0x4000 with defaults), plus half-word @0x31 -> each gives hresp=ERROR for 2 cycles (hreadyout 0 then 1); sram_cs never asserted.
- Write @0x40, then assert hresetn=0 during the WR_DATA cycle before the clock edge -> outputs at reset values immediately; read @0x40 after release shows the old contents.
- IDLE/BUSY transfers and hsel=0 -> hreadyout=1, hresp=OKAY, sram_cs=0 every cycle.
